// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader for the tile CCFF chain.
// It takes host words over a valid/ready handshake and shifts them LSB-first onto ccff_head.
// It holds config_enable high while a pass is active.
// In verify mode it re-streams the same bitstream and counts differences seen on ccff_tail.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    localparam int unsigned      BW        = $clog2(WORD_W + 1);
    localparam logic [BW-1:0]    WORD_BITS = BW'(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              verify_mode_q, verify_mode_d;
    logic [CNT_W-1:0]  bits_sent_q, bits_sent_d;
    logic [BW-1:0]     bits_left_q, bits_left_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  mismatch_d;
    logic              aborted_d;
    int unsigned       remaining;

    logic wr_ready_d, ccff_head_d, shift_en_d, config_enable_d, busy_d, done_d;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d       = state_q;
        verify_mode_d = verify_mode_q;
        bits_sent_d   = bits_sent_q;
        bits_left_d   = bits_left_q;
        shreg_d       = shreg_q;
        mismatch_d    = mismatch_cnt;
        aborted_d     = aborted;
        remaining     = CHAIN_LEN - 32'(bits_sent_q);

        if (abort && (state_q != IDLE)) begin
            // Abort wins over the handshake and any shift in the same cycle
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = FETCH;
                        verify_mode_d = verify;
                        bits_sent_d   = '0;
                        bits_left_d   = '0;
                        mismatch_d    = '0;
                        aborted_d     = 1'b0;
                    end
                end
                FETCH: begin
                    if (wr_valid && wr_ready) begin
                        shreg_d     = wr_data;
                        bits_left_d = (remaining < WORD_W) ? BW'(remaining) : WORD_BITS;
                        state_d     = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_d     = shreg_q >> 1;
                    bits_sent_d = bits_sent_q + CNT_W'(1);
                    bits_left_d = bits_left_q - BW'(1);
                    if (verify_mode_q && (ccff_tail != ccff_head) && (mismatch_cnt != CNT_MAX)) begin
                        mismatch_d = mismatch_cnt + CNT_W'(1);
                    end
                    if (bits_left_q == BW'(1)) begin
                        state_d = (bits_sent_q == LAST_BIT) ? DONE : FETCH;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        wr_ready_d      = (state_d == FETCH);
        shift_en_d      = (state_d == SHIFT);
        ccff_head_d     = (state_d == SHIFT) && shreg_d[0];
        busy_d          = (state_d == FETCH) || (state_d == SHIFT);
        config_enable_d = busy_d;
        done_d          = (state_d == DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q       <= IDLE;
            verify_mode_q <= 1'b0;
            bits_sent_q   <= '0;
            bits_left_q   <= '0;
            shreg_q       <= '0;
            mismatch_cnt  <= '0;
            aborted       <= 1'b0;
            wr_ready      <= 1'b0;
            ccff_head     <= 1'b0;
            shift_en      <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            verify_mode_q <= verify_mode_d;
            bits_sent_q   <= bits_sent_d;
            bits_left_q   <= bits_left_d;
            shreg_q       <= shreg_d;
            mismatch_cnt  <= mismatch_d;
            aborted       <= aborted_d;
            wr_ready      <= wr_ready_d;
            ccff_head     <= ccff_head_d;
            shift_en      <= shift_en_d;
            config_enable <= config_enable_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 64-bit chain instance and a 20-bit chain instance.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    logic pReset_n;

    logic        start, verify, abort, wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready, ccff_head, ccff_tail, shift_en, config_enable, busy, done, aborted;
    logic [15:0] mismatch_cnt;

    logic        start20, wr_valid20;
    logic [7:0]  wr_data20;
    logic        wr_ready20, ccff_head20, shift_en20, config_enable20, busy20, done20, aborted20;
    logic [15:0] mismatch_cnt20;

    int n_vec = 0;
    int n_err = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8), .CNT_W(16)) dut (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .verify(verify), .abort(abort),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .shift_en(shift_en), .config_enable(config_enable), .busy(busy),
        .done(done), .aborted(aborted), .mismatch_cnt(mismatch_cnt)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) dut20 (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start20), .verify(1'b0), .abort(1'b0),
        .wr_data(wr_data20), .wr_valid(wr_valid20), .wr_ready(wr_ready20), .ccff_head(ccff_head20),
        .ccff_tail(1'b0), .shift_en(shift_en20), .config_enable(config_enable20), .busy(busy20),
        .done(done20), .aborted(aborted20), .mismatch_cnt(mismatch_cnt20)
    );

    // Behavioural 64-bit chain: head enters at the top, tail is bit 0
    logic [63:0] chain = '0;
    assign ccff_tail = chain[0];

    logic head_hist [0:1023];
    logic head20    [0:31];
    int tot_shift = 0, tot_done = 0, tot_ce = 0;
    int tot_shift20 = 0, tot_done20 = 0;

    always @(posedge prog_clk) begin
        if (shift_en) begin
            chain <= {ccff_head, chain[63:1]};
            if (tot_shift < 1024) head_hist[10'(tot_shift)] <= ccff_head;
            tot_shift <= tot_shift + 1;
        end
        if (done) tot_done <= tot_done + 1;
        if (config_enable) tot_ce <= tot_ce + 1;
        if (shift_en20) begin
            if (tot_shift20 < 32) head20[5'(tot_shift20)] <= ccff_head20;
            tot_shift20 <= tot_shift20 + 1;
        end
        if (done20) tot_done20 <= tot_done20 + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] words [0:7];
    int base_shift, base_done, base_ce, hs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [63:0] head_vec(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[6'(i)] = head_hist[10'(base + i)];
        return v;
    endfunction

    // One full pass on the 64-bit instance; optional host stall and start pokes while busy
    task automatic run_pass(input logic vmode, input int stall, input bit poke);
        int widx = 0;
        bit hs;
        bit seen = 1'b0;
        base_shift = tot_shift;
        base_done  = tot_done;
        base_ce    = tot_ce;
        hs_cnt     = 0;
        verify = vmode;
        start  = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_fetch", 64'({wr_ready, shift_en, config_enable}), 64'(3'b101));
            step();
        end
        wr_data  = words[0];
        wr_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            if (poke) start = (shift_en && ((tot_shift - base_shift) == 30)) || (wr_ready && widx == 5);
            hs = wr_ready && wr_valid;
            step();
            if (hs) begin
                widx++;
                hs_cnt++;
                wr_data = (widx < 8) ? words[3'(widx)] : 8'h00;
            end
            seen = done;
        end
        start    = 1'b0;
        wr_valid = 1'b0;
        chk("done_seen", 64'(seen), 64'(1));
    endtask

    logic [7:0] w20 [0:2];
    logic [19:0] v20;
    int idx20, hs20, widx;
    bit hs, seen20, found;

    initial begin
        pReset_n = 1'b0;
        start = 1'b0; verify = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        start20 = 1'b0; wr_valid20 = 1'b0; wr_data20 = 8'h00;
        #12;
        chk("rst_outputs", 64'({wr_ready, ccff_head, shift_en, config_enable, busy, done, aborted}), 64'(0));
        chk("rst_mismatch", 64'(mismatch_cnt), 64'(0));
        chk("rst_outputs20", 64'({wr_ready20, ccff_head20, shift_en20, config_enable20, busy20, done20, aborted20, mismatch_cnt20}), 64'(0));
        pReset_n = 1'b1;
        step();

        // Asynchronous reset in the middle of SHIFT
        for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
        start = 1'b1; verify = 1'b0;
        step();
        start = 1'b0;
        chk("start_busy", 64'({busy, config_enable, wr_ready}), 64'(3'b111));
        wr_data = words[0]; wr_valid = 1'b1;
        step();
        step();
        step();
        chk("pre_reset_shift", 64'(shift_en), 64'(1));
        #2 pReset_n = 1'b0;
        #1;
        chk("async_reset", 64'({wr_ready, ccff_head, shift_en, config_enable, busy, done, aborted}), 64'(0));
        #2 pReset_n = 1'b1;
        wr_valid = 1'b0;
        step();

        // Clean full load of 0x01..0x08
        run_pass(1'b0, 0, 1'b0);
        chk("load_done_state", 64'({done, busy, config_enable, shift_en}), 64'(4'b1000));
        chk("load_shifts", 64'(tot_shift - base_shift), 64'(64));
        chk("load_handshakes", 64'(hs_cnt), 64'(8));
        chk("load_head_seq", head_vec(base_shift, 64), 64'h0807060504030201);
        chk("load_ce_cycles", 64'(tot_ce - base_ce), 64'(72));
        step();
        chk("load_done_pulses", 64'(tot_done - base_done), 64'(1));
        chk("done_one_cycle", 64'(done), 64'(0));

        // Load a new pattern, then verify against it (clean and with one flipped bit)
        words[0] = 8'h3C; words[1] = 8'h5A; words[2] = 8'h96; words[3] = 8'hE1;
        words[4] = 8'h0F; words[5] = 8'h77; words[6] = 8'h81; words[7] = 8'hC3;
        run_pass(1'b0, 0, 1'b0);
        chk("load_mode_mismatch", 64'(mismatch_cnt), 64'(0));
        chk("chain_contents", chain, 64'hC381770FE1965A3C);
        step();
        run_pass(1'b1, 0, 1'b0);
        chk("verify_clean", 64'(mismatch_cnt), 64'(0));
        chk("verify_shifts", 64'(tot_shift - base_shift), 64'(64));
        step();
        words[3] = words[3] ^ 8'h04;
        run_pass(1'b1, 0, 1'b0);
        chk("verify_one_flip", 64'(mismatch_cnt), 64'(1));
        step();
        step();
        chk("mismatch_holds_idle", 64'(mismatch_cnt), 64'(1));

        // Verify with host stall and start pulses while busy
        words[3] = words[3] ^ 8'h04;
        run_pass(1'b1, 10, 1'b1);
        chk("stall_mismatch", 64'(mismatch_cnt), 64'(1));
        chk("stall_shifts", 64'(tot_shift - base_shift), 64'(64));
        chk("stall_handshakes", 64'(hs_cnt), 64'(8));
        chk("stall_ce_cycles", 64'(tot_ce - base_ce), 64'(82));
        step();
        chk("stall_done_pulses", 64'(tot_done - base_done), 64'(1));

        // Short chain: third word shifts only 4 bits
        w20[0] = 8'hFF; w20[1] = 8'h00; w20[2] = 8'hA5;
        idx20 = 0; hs20 = 0; seen20 = 1'b0;
        start20 = 1'b1;
        step();
        start20 = 1'b0;
        wr_data20 = w20[0]; wr_valid20 = 1'b1;
        for (int cyc = 0; cyc < 60 && !seen20; cyc++) begin
            hs = wr_ready20 && wr_valid20;
            step();
            if (hs) begin
                idx20++;
                hs20++;
                wr_data20 = (idx20 < 3) ? w20[2'(idx20)] : 8'h00;
            end
            seen20 = done20;
        end
        wr_valid20 = 1'b0;
        chk("short_done_seen", 64'(seen20), 64'(1));
        chk("short_handshakes", 64'(hs20), 64'(3));
        chk("short_shifts", 64'(tot_shift20), 64'(20));
        v20 = '0;
        for (int i = 0; i < 20; i++) v20[5'(i)] = head20[5'(i)];
        chk("short_head_seq", 64'(v20), 64'(20'h500FF));
        chk("short_done_state", 64'({busy20, config_enable20}), 64'(0));
        step();
        chk("short_done_pulses", 64'(tot_done20), 64'(1));

        // Abort on the 5th SHIFT cycle of word 2
        base_shift = tot_shift; base_done = tot_done;
        widx = 0; found = 1'b0;
        start = 1'b1; verify = 1'b0;
        step();
        start = 1'b0;
        wr_data = words[0]; wr_valid = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (shift_en && ((tot_shift - base_shift) == 12)) begin
                found = 1'b1;
                break;
            end
            hs = wr_ready && wr_valid;
            step();
            if (hs) begin
                widx++;
                wr_data = words[3'(widx)];
            end
        end
        chk("abort_point_found", 64'(found), 64'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", 64'({shift_en, config_enable, busy, wr_ready, aborted}), 64'(5'b00001));
        repeat (12) step();
        chk("abort_no_done", 64'(tot_done - base_done), 64'(0));
        chk("abort_sticky", 64'(aborted), 64'(1));

        // Following start clears aborted; abort in FETCH refuses the offered word
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_aborted", 64'({aborted, busy}), 64'(2'b01));
        base_shift = tot_shift;
        abort = 1'b1; wr_valid = 1'b1;
        step();
        abort = 1'b0; wr_valid = 1'b0;
        chk("abort_fetch", 64'({shift_en, wr_ready, busy, aborted}), 64'(4'b0001));
        step();
        step();
        chk("abort_word_dropped", 64'(tot_shift - base_shift), 64'(0));

        // Clean pass after abort
        run_pass(1'b0, 0, 1'b0);
        chk("post_abort_shifts", 64'(tot_shift - base_shift), 64'(64));
        chk("post_abort_flags", 64'({aborted, mismatch_cnt}), 64'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller for the logic-tile configuration flip-flop chain (e.g. the 2-bit FF MODE_SEL memories, concatenated across a tile).
- Accepts bitstream words from a host over a valid/ready interface, serialises them LSB-first onto ccff_head, and gates chain shifting.
- Drives config_enable for the duration of a load.
- Optional verify pass re-streams the same bitstream and compares ccff_tail against it, counting mismatches.

Parameters:
- CHAIN_LEN, 64: total configuration bits in the chain (≥1).
- WORD_W, 8: host word width (≥1).
- CNT_W, 16: width of the bit counter and the mismatch counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; all state changes on its rising edge.
- pReset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a pass; honoured only in IDLE.
- verify  in  1  sampled with start; 1 = verify pass, 0 = load pass.
- abort  in  1  terminates any pass immediately.
- wr_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- wr_valid  in  1  host word valid.
- wr_ready  out  1  controller accepts a word this cycle.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain.
- shift_en  out  1  chain advances one bit at the prog_clk edge ending this cycle.
- config_enable  out  1  chain configuration-enable gate.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  sticky; set by abort, cleared by the next accepted start.
- mismatch_cnt  out  CNT_W  verify mismatches; saturating.

Behaviour:
- Reset (pReset_n=0, asynchronous): state=IDLE. All outputs are 0: wr_ready, ccff_head, shift_en, config_enable, busy, done, aborted, and mismatch_cnt. Internal bit and word counters are cleared.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start=1 goes to FETCH in the next cycle.
  - Latches verify into the internal mode, clears the bit counter (bits_sent) and mismatch_cnt, and clears aborted.
  - config_enable and busy are 1 from the cycle after start.
- FETCH:
  - wr_ready=1. On wr_valid&&wr_ready, latch wr_data into the shift register and go to SHIFT.
  - Set bits_in_word = min(WORD_W, CHAIN_LEN-bits_sent).
  - wr_ready is 0 in every other state, and never combinationally depends on wr_valid.
- SHIFT:
  - shift_en=1 and ccff_head=shreg[0] for exactly bits_in_word consecutive cycles.
  - Each cycle: shreg shifts right and bits_sent increments.
  - Unused upper bits of the final partial word are discarded, never shifted.
  - After the last bit of a word: if bits_sent==CHAIN_LEN go to DONE, else go to FETCH.
  - FETCH inserts at least one idle cycle (shift_en=0) between words; the chain holds during it.
- Verify compare:
  - Applies in verify mode, on each SHIFT cycle.
  - If ccff_tail != ccff_head, mismatch_cnt increments, saturating at 2^CNT_W-1.
  - Valid because the tail bit presented before a shift edge equals the same-index bit of the previous pass.
  - Re-streaming the bitstream leaves chain contents unchanged.
  - In load mode mismatch_cnt stays 0.
- DONE (one cycle):
  - done=1, config_enable falls to 0, busy falls to 0.
  - Returns to IDLE. mismatch_cnt holds its value until the next start.
- abort=1 in any non-IDLE state:
  - Next state is IDLE. shift_en, config_enable, busy, and wr_ready go to 0 in the next cycle; no done pulse; aborted=1.
  - A word presented in the abort cycle is not accepted.
  - abort in IDLE is ignored.
  - abort has priority over start and over the handshake in the same cycle.
- start while busy is ignored; it does not restart the pass or clear counters.
- Host stall: FETCH waits indefinitely with wr_ready=1, shift_en=0, config_enable=1.
- CHAIN_LEN < WORD_W: exactly one word is fetched and only CHAIN_LEN bits are shifted.
- Total shift_en pulses per completed pass is exactly CHAIN_LEN.

Test Plan:
1. Reset mid-SHIFT (pReset_n low asynchronously) -> all outputs 0 within the same cycle; state IDLE; next start performs a full clean pass.
2. CHAIN_LEN=64, WORD_W=8, load of 8 words 0x01..0x08 with wr_valid always 1 -> exactly 64 shift_en pulses; ccff_head sequence LSB-first per word; one done pulse; config_enable high start+1 through the last SHIFT cycle.
3. CHAIN_LEN=20, WORD_W=8, load of words 0xFF,0x00,0xA5 -> 3 handshakes; third word shifts only 4 bits (1,0,1,0); then done.
4. Load a pattern into a behavioural 64-bit chain model, then verify with the same pattern -> mismatch_cnt=0. Repeat verify with word 3 bit 2 flipped -> mismatch_cnt=1.
5. abort asserted on the 5th SHIFT cycle of word 2 -> next cycle shift_en=0, config_enable=0, busy=0, aborted=1, no done pulse; a following start clears aborted.
6. Host holds wr_valid=0 for 10 cycles in FETCH -> wr_ready=1 throughout, no shift_en; start pulses during the pass leave bits_sent and mismatch_cnt unchanged.
